multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles spent waiting for i_mem_ready before fault.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_opcode  input  6  instruction opcode field [31:26] from the instruction register.
REQ-005 SHALL have port i_mem_ready  input  1  memory handshake; transfer completes in the cycle it is high while o_mem_req is high.
REQ-006 SHALL have port o_mem_req  output  1  memory access request.
REQ-007 SHALL have port o_mem_we  output  1  memory write strobe, qualified by o_mem_req.
REQ-008 SHALL have port o_ir_we  output  1  instruction register load enable.
REQ-009 SHALL have port o_pc_we  output  1  PC load enable (PC takes the execute-stage next PC).
REQ-010 SHALL have port o_reg_we  output  1  register file write enable.
REQ-011 SHALL have port o_memtoreg  output  1  write-back source; 1 = memory data.
REQ-012 SHALL have port o_regdst  output  1  destination select; 1 = rd, 0 = rt.
REQ-013 SHALL have ports o_ALUSrc (1), o_ALUop (2), o_jump (1), o_beq (1), o_bne (1), o_extOp (1), all outputs, driving the execute stage.
REQ-014 SHALL have port o_fault  output  1  sticky fault indication.
REQ-015 SHALL have port o_state  output  3  current state code.

Function
REQ-016 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
REQ-017 FETCH SHALL assert o_mem_req with o_mem_we=0; on i_mem_ready=1 it SHALL assert o_ir_we for that cycle and go to DECODE; otherwise it SHALL stay.
REQ-018 DECODE SHALL last one cycle, latch i_opcode internally, and go to EXEC for supported opcodes or to FAULT for any other opcode.
REQ-019 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, ori 001101.
REQ-020 From DECODE through the last state of an instruction, the control outputs SHALL be decoded from the latched opcode and held stable, with values per instruction as follows:
- R-type: ALUSrc 0, ALUop 10, regdst 1.
- addi, lw, sw: ALUSrc 1, ALUop 00, extOp 1.
- ori: ALUSrc 1, ALUop 11, extOp 0.
- beq, bne: ALUSrc 0, ALUop 01, extOp 1, with beq or bne respectively = 1.
- j: jump 1.
REQ-021 All control outputs not listed for the instruction SHALL be 0, and all SHALL be 0 in FETCH and FAULT.
REQ-022 EXEC SHALL take one cycle:
- beq, bne, j: assert o_pc_we, then go to FETCH.
- R-type, addi, ori: go to WB.
- lw, sw: go to MEM.
REQ-023 MEM SHALL assert o_mem_req with o_mem_we=1 for sw and 0 for lw, and wait for i_mem_ready:
- sw: assert o_pc_we in the ready cycle, then go to FETCH.
- lw: go to WB.
REQ-024 WB SHALL take one cycle, asserting o_reg_we and o_pc_we; o_memtoreg SHALL be 1 for lw only.
REQ-025 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without i_mem_ready; reaching TIMEOUT SHALL move to FAULT with no o_ir_we, o_pc_we or o_reg_we pulse.
REQ-026 If i_mem_ready is high in the same cycle the counter reaches TIMEOUT, the transfer SHALL complete and no fault SHALL occur.
REQ-027 FAULT SHALL be absorbing until reset, holding o_fault=1 and all enables at 0.
REQ-028 Every instruction SHALL produce exactly one o_pc_we pulse. Latency from FETCH ready to that pulse:
- j, beq, bne: 2 cycles.
- R-type, addi, ori: 3 cycles.
- sw, lw: at least 3 and 4 cycles respectively, plus memory wait cycles.

Reset
REQ-029 Asserting i_rst_n low SHALL immediately force FETCH, clear the wait counter, clear o_fault and the latched opcode, and drive every output to 0 except o_mem_req.
REQ-030 After reset release, o_mem_req SHALL be 1 in the first cycle (FETCH).
REQ-031 Reset in the middle of an instruction SHALL abandon it without any o_pc_we or o_reg_we pulse.

Configuration
REQ-032 With macro MULTICYCLE_CTRL_RETIRE_CNT_EN defined, the block SHALL add output o_retired (32 bits), reset to 0, which increments by one on each o_pc_we pulse and wraps from 0xFFFFFFFF to 0.
REQ-033 Without MULTICYCLE_CTRL_RETIRE_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-034 Bench: i_mem_ready held at 1, opcode 000000 -> states 0,1,2,4,0; o_reg_we=1 and o_pc_we=1 in the WB cycle only, with regdst=1 and ALUop=10.
REQ-035 Bench: opcode 100011 with memory ready 2 cycles late in MEM -> MEM lasts 3 cycles with o_mem_we=0, then WB with memtoreg=1.
REQ-036 Bench: opcode 101011 -> in MEM o_mem_req=1 and o_mem_we=1; o_pc_we in the ready cycle; o_reg_we never asserted.
REQ-037 Bench: opcode 111111 -> FAULT after DECODE with o_fault=1 held for 20 cycles; i_rst_n pulse -> FETCH with o_fault=0.
REQ-038 Bench: i_mem_ready held at 0 in FETCH with TIMEOUT=16 -> FAULT after 16 cycles; in a separate run, ready arriving exactly at cycle 16 -> DECODE.
REQ-039 Bench: macro defined, 5 instructions of type j -> o_retired=5; reset asserted mid-EXEC -> o_retired=0 and no o_pc_we pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait timeout to a sticky FAULT state.
// Each instruction pulses o_pc_we 2-4 cycles after fetch, plus memory waits. Optional o_retired counter under MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic        o_reg_we,
  output logic        o_memtoreg,
  output logic        o_regdst,
  output logic        o_ALUSrc,
  output logic [1:0]  o_ALUop,
  output logic        o_jump,
  output logic        o_beq,
  output logic        o_bne,
  output logic        o_extOp,
  output logic        o_fault,
  output logic [2:0]  o_state
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] o_retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       extop;
    logic       regdst;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam int         CW      = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [5:0]    op_q;
  logic [5:0]    op_cur;
  logic [CW-1:0] wait_cnt;
  ctrl_t         dec;
  logic          legal;
  logic          in_instr;
  logic          is_lw, is_sw, is_flow;
  logic          xfer_wait;
  logic          expired;

  // The IR is loaded at the end of FETCH, so DECODE sees the opcode live; later states use the latched copy.
  assign op_cur = (state == S_DECODE) ? i_opcode : op_q;

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (op_cur)
      OP_R:                 begin dec.aluop = 2'b10; dec.regdst = 1'b1; end
      OP_ADDI, OP_LW, OP_SW: begin dec.alusrc = 1'b1; dec.extop = 1'b1; end
      OP_ORI:               begin dec.alusrc = 1'b1; dec.aluop = 2'b11; end
      OP_BEQ:               begin dec.aluop = 2'b01; dec.extop = 1'b1; dec.beq = 1'b1; end
      OP_BNE:               begin dec.aluop = 2'b01; dec.extop = 1'b1; dec.bne = 1'b1; end
      OP_J:                 dec.jump = 1'b1;
      default:              legal = 1'b0;
    endcase
  end

  assign is_lw     = (op_cur == OP_LW);
  assign is_sw     = (op_cur == OP_SW);
  assign is_flow   = (op_cur == OP_BEQ) || (op_cur == OP_BNE) || (op_cur == OP_J);
  assign in_instr  = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
  assign xfer_wait = ((state == S_FETCH) || (state == S_MEM)) && !i_mem_ready;
  assign expired   = xfer_wait && (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (i_mem_ready) state_nxt = S_DECODE;
                else if (expired) state_nxt = S_FAULT;
      S_DECODE: state_nxt = legal ? S_EXEC : S_FAULT;
      S_EXEC:   if (is_flow) state_nxt = S_FETCH;
                else if (is_lw || is_sw) state_nxt = S_MEM;
                else state_nxt = S_WB;
      S_MEM:    if (i_mem_ready) state_nxt = is_sw ? S_FETCH : S_WB;
                else if (expired) state_nxt = S_FAULT;
      S_WB:     state_nxt = S_FETCH;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        op_q <= i_opcode;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (xfer_wait)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Handshake strobes follow i_mem_ready combinationally; ir_we is masked while reset is held.
  assign o_mem_req  = (state == S_FETCH) || (state == S_MEM);
  assign o_mem_we   = (state == S_MEM) && is_sw;
  assign o_ir_we    = i_rst_n && (state == S_FETCH) && i_mem_ready;
  assign o_pc_we    = ((state == S_EXEC) && is_flow) ||
                      ((state == S_MEM) && is_sw && i_mem_ready) ||
                      (state == S_WB);
  assign o_reg_we   = (state == S_WB);
  assign o_memtoreg = (state == S_WB) && is_lw;
  assign o_regdst   = in_instr && dec.regdst;
  assign o_ALUSrc   = in_instr && dec.alusrc;
  assign o_ALUop    = in_instr ? dec.aluop : 2'b00;
  assign o_jump     = in_instr && dec.jump;
  assign o_beq      = in_instr && dec.beq;
  assign o_bne      = in_instr && dec.bne;
  assign o_extOp    = in_instr && dec.extop;
  assign o_fault    = (state == S_FAULT);
  assign o_state    = state;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_retired <= '0;
    else if (o_pc_we)
      o_retired <= o_retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction expected cycle traces are built from the
// instruction table and timing rules, then replayed against the DUT one cycle at a time.
module tb_multicycle_ctrl;

  localparam int TO = 16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [5:0]  i_opcode;
  logic        i_mem_ready;
  logic        o_mem_req, o_mem_we, o_ir_we, o_pc_we, o_reg_we, o_memtoreg, o_regdst;
  logic        o_ALUSrc, o_jump, o_beq, o_bne, o_extOp, o_fault;
  logic [1:0]  o_ALUop;
  logic [2:0]  o_state;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] o_retired;
`endif

  always #5 i_clk = ~i_clk;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we),
    .o_reg_we(o_reg_we), .o_memtoreg(o_memtoreg), .o_regdst(o_regdst), .o_ALUSrc(o_ALUSrc),
    .o_ALUop(o_ALUop), .o_jump(o_jump), .o_beq(o_beq), .o_bne(o_bne), .o_extOp(o_extOp),
    .o_fault(o_fault), .o_state(o_state)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    , .o_retired(o_retired)
`endif
  );

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we, memtoreg, regdst, alusrc;
    logic [1:0] aluop;
    logic       jump, beq, bne, extop, fault;
  } out_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] opc;
    logic [15:0] idx;
    out_t       exp;
  } cyc_t;

  cyc_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ret = '0;
  logic [5:0]  ops[8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t observed();
    out_t o;
    o.state = o_state;   o.mem_req = o_mem_req; o.mem_we = o_mem_we; o.ir_we = o_ir_we;
    o.pc_we = o_pc_we;   o.reg_we = o_reg_we;   o.memtoreg = o_memtoreg; o.regdst = o_regdst;
    o.alusrc = o_ALUSrc; o.aluop = o_ALUop;     o.jump = o_jump; o.beq = o_beq;
    o.bne = o_bne;       o.extop = o_extOp;     o.fault = o_fault;
    return o;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI};
  endfunction

  // Instruction table: control values held from DECODE to the end of the instruction.
  function automatic out_t ctrl_of(input logic [5:0] op);
    out_t o = '0;
    case (op)
      OP_R:                  begin o.aluop = 2'b10; o.regdst = 1'b1; end
      OP_ADDI, OP_LW, OP_SW: begin o.alusrc = 1'b1; o.extop = 1'b1; end
      OP_ORI:                begin o.alusrc = 1'b1; o.aluop = 2'b11; end
      OP_BEQ:                begin o.aluop = 2'b01; o.extop = 1'b1; o.beq = 1'b1; end
      OP_BNE:                begin o.aluop = 2'b01; o.extop = 1'b1; o.bne = 1'b1; end
      OP_J:                  o.jump = 1'b1;
      default:               o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic [5:0] opc, input int idx, input out_t e);
    cyc_t c;
    c.rdy = rdy; c.opc = opc; c.idx = 16'(idx); c.exp = e;
    q.push_back(c);
  endtask

  // fd/md = memory-not-ready cycles before ready in FETCH/MEM; >= TO means the transfer times out.
  task automatic gen(input logic [5:0] op, input int fd, input int md, input int idx, output bit faulted);
    out_t e;
    bit   flow, mem;
    faulted = 0;
    flow = op inside {OP_BEQ, OP_BNE, OP_J};
    mem  = op inside {OP_LW, OP_SW};
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < fd && i < TO; i++) push(1'b0, rnd6(), idx, e);
    if (fd >= TO) begin faulted = 1; return; end
    e.ir_we = 1'b1;
    push(1'b1, rnd6(), idx, e);
    e = ctrl_of(op); e.state = 3'd1;
    push(rnd1(), op, idx, e);
    if (!legal(op)) begin faulted = 1; return; end
    e.state = 3'd2; e.pc_we = flow;
    push(rnd1(), rnd6(), idx, e);
    if (flow) return;
    if (mem) begin
      e = ctrl_of(op); e.state = 3'd3; e.mem_req = 1'b1; e.mem_we = (op == OP_SW);
      for (int i = 0; i < md && i < TO; i++) push(1'b0, rnd6(), idx, e);
      if (md >= TO) begin faulted = 1; return; end
      e.pc_we = (op == OP_SW);
      push(1'b1, rnd6(), idx, e);
      if (op == OP_SW) return;
    end
    e = ctrl_of(op); e.state = 3'd4; e.reg_we = 1'b1; e.pc_we = 1'b1; e.memtoreg = (op == OP_LW);
    push(rnd1(), rnd6(), idx, e);
  endtask

  task automatic gen_fault(input int n, input int idx);
    out_t e = '0;
    e.state = 3'd7; e.fault = 1'b1;
    for (int i = 0; i < n; i++) push(rnd1(), rnd6(), idx, e);
  endtask

  task automatic step(input cyc_t c);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_mem_ready = c.rdy;
    i_opcode = c.opc;
    #1;
    chk($sformatf("i%0d_st%0d", c.idx, c.exp.state), {14'b0, observed()}, {14'b0, c.exp});
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    chk($sformatf("i%0d_retired", c.idx), o_retired, exp_ret);
`endif
    if (c.exp.pc_we) exp_ret = exp_ret + 32'd1;
  endtask

  task automatic run_q();
    while (q.size() > 0) step(q.pop_front());
  endtask

  // Holds reset for two cycles with ready high; the next step() releases it at a falling edge.
  task automatic do_reset(input string tag);
    out_t e = '0;
    e.mem_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      i_rst_n = 1'b0; i_mem_ready = 1'b1; i_opcode = rnd6();
      #1;
      chk(tag, {14'b0, observed()}, {14'b0, e});
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
      chk({tag, "_retired"}, o_retired, 32'd0);
`endif
    end
    exp_ret = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int idx = 0;
    i_rst_n = 1'b0; i_mem_ready = 1'b0; i_opcode = '0;
    do_reset("por");

    gen(OP_R, 0, 0, idx++, f); run_q();
    gen(OP_LW, 0, 2, idx++, f); run_q();
    gen(OP_SW, 1, 1, idx++, f); run_q();
    gen(OP_ORI, 2, 0, idx++, f); run_q();
    gen(OP_BEQ, 0, 0, idx++, f); run_q();

    gen(6'b111111, 0, 0, idx, f); gen_fault(20, idx++); run_q();
    do_reset("rst_after_illegal");
    gen(OP_ADDI, 0, 0, idx++, f); run_q();

    gen(OP_J, TO, 0, idx, f); gen_fault(3, idx++); run_q();
    do_reset("rst_after_fetch_to");
    gen(OP_J, TO - 1, 0, idx++, f); run_q();
    gen(OP_LW, 0, TO, idx, f); gen_fault(3, idx++); run_q();
    do_reset("rst_after_mem_to");
    gen(OP_SW, 0, TO - 1, idx++, f); run_q();

    // Five jumps, then a reset landing in the EXEC cycle of a sixth.
    do_reset("rst_before_jumps");
    for (int k = 0; k < 5; k++) begin gen(OP_J, 0, 0, idx++, f); run_q(); end
    gen(OP_J, 0, 0, idx++, f);
    while (q.size() > 1) step(q.pop_front());
    void'(q.pop_front());
    @(negedge i_clk);
    #1;
    chk("pre_rst_exec_state", 32'(o_state), 32'd2);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    chk("retired_after_5j", o_retired, 32'd5);
`endif
    i_rst_n = 1'b0;
    #1;
    chk("mid_exec_rst_pc_we", 32'(o_pc_we), 32'd0);
    chk("mid_exec_rst_state", 32'(o_state), 32'd0);
    do_reset("mid_exec_rst");

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      int fd, md;
      op = ($urandom_range(0, 9) == 0) ? rnd6() : ops[$urandom_range(0, 7)];
      fd = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 1);
      md = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 1);
      gen(op, fd, md, idx, f);
      if (f) gen_fault(4, idx);
      idx++;
      run_q();
      if (f) do_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
